// File: rtl/link_pair_receiver.sv
// rtl/link_pair_receiver.sv - differential Manchester receive end: sync, bit recovery, framing, byte handshake
module link_pair_receiver #(
  parameter int SAMPLES_PER_BIT = 8,
  parameter int PREAMBLE_MIN    = 16
) (
  input  logic       Clock100Mhz,
  input  logic       ResetN,
  input  logic       LinePairP,
  input  logic       LinePairN,
  output logic [7:0] DataOut,
  output logic       DataValid,
  input  logic       DataReady,
  output logic       FrameActive,
  output logic       FrameDone,
  output logic       FrameError,
  output logic       Overrun,
  input  logic       ClearStatus
);

  localparam int PW = $clog2(2 * SAMPLES_PER_BIT) + 1;
  localparam int CW = $clog2(PREAMBLE_MIN + 1);
  localparam logic [PW-1:0] MID_MIN = PW'((3 * SAMPLES_PER_BIT) / 4);
  localparam logic [PW-1:0] LOSS    = PW'((3 * SAMPLES_PER_BIT) / 2);
  localparam logic [PW-1:0] PH_MAX  = '1;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;
  state_t state, state_next;

  logic [1:0]    p_sync, n_sync;
  logic          valid_s, level_s, prev_valid, prev_level;
  logic [PW-1:0] phase, phase_now;
  logic          edge_seen, mid_edge, loss, fault;
  logic [CW-1:0] pre_cnt;
  logic          last_bit;
  logic [6:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          shift_en, byte_done, done_c, err_c;
  logic          byte_strobe;
  logic [7:0]    byte_data;
  logic          xfer;

  assign valid_s   = p_sync[1] ^ n_sync[1];
  assign level_s   = p_sync[1];
  assign edge_seen = valid_s && prev_valid && (level_s != prev_level);
  // phase_now is the sample count since the last mid-bit edge as of this sample
  assign phase_now = (phase == PH_MAX) ? PH_MAX : phase + PW'(1);
  assign mid_edge  = edge_seen && ((state == IDLE) || (phase_now >= MID_MIN));
  assign loss      = (state != IDLE) && !mid_edge && (phase_now == LOSS);
  assign fault     = (state != IDLE) && !valid_s && !prev_valid;

  always_ff @(posedge Clock100Mhz or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (mid_edge) state_next = PREAMBLE;
      PREAMBLE: begin
        if (fault || loss) state_next = IDLE;
        else if (mid_edge && (level_s == last_bit))
          state_next = (level_s && (pre_cnt >= CW'(PREAMBLE_MIN))) ? DATA : IDLE;
      end
      DATA:     if (fault || loss) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    FrameActive = (state == DATA);
    shift_en    = (state == DATA) && mid_edge;
    byte_done   = shift_en && (bit_cnt == 3'd7);
    done_c      = (state == DATA) && (fault || loss);
    err_c       = fault || (bit_cnt != 3'd0);
  end

  always_ff @(posedge Clock100Mhz or negedge ResetN) begin
    if (!ResetN) begin
      p_sync      <= '0;
      n_sync      <= '0;
      prev_valid  <= 1'b0;
      prev_level  <= 1'b0;
      phase       <= PH_MAX;
      last_bit    <= 1'b0;
      pre_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      byte_strobe <= 1'b0;
      byte_data   <= '0;
      FrameDone   <= 1'b0;
      FrameError  <= 1'b0;
    end else begin
      p_sync      <= {p_sync[0], LinePairP};
      n_sync      <= {n_sync[0], LinePairN};
      prev_valid  <= valid_s;
      prev_level  <= level_s;
      phase       <= mid_edge ? '0 : phase_now;
      if (mid_edge) last_bit <= level_s;
      if (state == IDLE && mid_edge)
        pre_cnt <= CW'(1);
      else if (state == PREAMBLE && mid_edge && level_s != last_bit && pre_cnt < CW'(PREAMBLE_MIN))
        pre_cnt <= pre_cnt + CW'(1);
      if (state != DATA)  bit_cnt <= '0;
      else if (shift_en)  bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shreg <= {level_s, shreg[6:1]};
      byte_strobe <= byte_done;
      if (byte_done) byte_data <= {level_s, shreg};
      FrameDone   <= done_c;
      FrameError  <= done_c && err_c;
    end
  end

  // A new byte may replace the held one only when it is being taken this cycle
  assign xfer = DataValid && DataReady;

  always_ff @(posedge Clock100Mhz or negedge ResetN) begin
    if (!ResetN) begin
      DataOut   <= '0;
      DataValid <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      if (byte_strobe && (!DataValid || xfer)) begin
        DataOut   <= byte_data;
        DataValid <= 1'b1;
      end else if (xfer) begin
        DataValid <= 1'b0;
      end
      if (byte_strobe && DataValid && !DataReady) Overrun <= 1'b1;
      else if (ClearStatus)                       Overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_link_pair_receiver.sv
// tb/tb_link_pair_receiver.sv - scoreboard bench for link_pair_receiver
module tb_link_pair_receiver;

  logic       clk = 1'b0;
  logic       ResetN, LinePairP, LinePairN, DataReady, ClearStatus;
  logic [7:0] DataOut;
  logic       DataValid, FrameActive, FrameDone, FrameError, Overrun;

  link_pair_receiver #(.SAMPLES_PER_BIT(8), .PREAMBLE_MIN(16)) dut (
    .Clock100Mhz(clk), .ResetN(ResetN), .LinePairP(LinePairP), .LinePairN(LinePairN),
    .DataOut(DataOut), .DataValid(DataValid), .DataReady(DataReady),
    .FrameActive(FrameActive), .FrameDone(FrameDone), .FrameError(FrameError),
    .Overrun(Overrun), .ClearStatus(ClearStatus)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   total = 0, bad = 0;
  int   mid_cyc = 0, done_cyc = -1;
  logic saw_active = 1'b0, saw_valid = 1'b0;
  logic [7:0] exp_bytes[$];
  logic       exp_done[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over a byte or ends a frame
  always @(negedge clk) begin
    if (ResetN === 1'b1) begin
      if (FrameActive) saw_active = 1'b1;
      if (DataValid)   saw_valid  = 1'b1;
      if (DataValid && DataReady) begin
        if (exp_bytes.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_byte: got %0h required none", DataOut);
        end else check("byte", {24'd0, DataOut}, {24'd0, exp_bytes.pop_front()});
      end
      if (FrameDone) begin
        done_cyc = cyc;
        if (exp_done.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got error=%0b required none", FrameError);
        end else check("frame_error", {31'd0, FrameError}, {31'd0, exp_done.pop_front()});
      end
    end
  end

  task automatic sample(input logic p, input logic n);
    LinePairP = p;
    LinePairN = n;
    @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b, input int t);
    for (int i = 0; i < t - 4; i++) sample(~b, b);
    mid_cyc = cyc;
    for (int i = 0; i < 4; i++) sample(b, ~b);
  endtask

  task automatic send_byte(input logic [7:0] v, input int t0, input int t1);
    for (int i = 0; i < 8; i++) send_bit(v[i], (i % 2 == 0) ? t0 : t1);
  endtask

  task automatic preamble(input int n, input logic sfd);
    for (int i = 0; i < n; i++) send_bit((i % 2 == 0) ? 1'b1 : 1'b0, 8);
    if (sfd) begin
      send_bit(1'b1, 8);
      send_bit(1'b1, 8);
    end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) sample(LinePairP, LinePairN);
  endtask

  task automatic idle_line(input int n);
    for (int i = 0; i < n; i++) sample(1'b0, 1'b0);
  endtask

  function automatic logic [12:0] outs();
    return {DataOut, DataValid, FrameActive, FrameDone, FrameError, Overrun};
  endfunction

  initial begin
    ResetN = 1'b0; DataReady = 1'b0; ClearStatus = 1'b0;
    LinePairP = 1'b0; LinePairN = 1'b0;
    // Reset held with random line activity
    for (int i = 0; i < 20; i++) begin
      LinePairP = 1'($urandom_range(0, 1));
      LinePairN = 1'($urandom_range(0, 1));
      @(posedge clk); #2;
      if (i == 5 || i == 19) check("reset_outputs", {19'd0, outs()}, 32'd0);
    end
    LinePairP = 1'b0; LinePairN = 1'b0;
    ResetN = 1'b1;
    idle_line(40);
    check("idle_outputs", {19'd0, outs()}, 32'd0);
    check("idle_no_activity", {30'd0, saw_active, saw_valid}, 32'd0);

    // Basic frame: A5, 3C with DataReady held high
    DataReady = 1'b1;
    preamble(16, 1'b1);
    check("sfd_frame_active", {31'd0, FrameActive}, 32'd1);
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(8'h3C);
    send_byte(8'hA5, 8, 8);
    send_byte(8'h3C, 8, 8);
    exp_done.push_back(1'b0);
    done_cyc = -1;
    hold(20);
    check("done_latency", done_cyc - mid_cyc, 32'd15);
    check("basic_active_low", {31'd0, FrameActive}, 32'd0);
    check("basic_bytes_left", exp_bytes.size(), 32'd0);
    check("basic_done_left", exp_done.size(), 32'd0);
    idle_line(10);

    // Backpressure: only 0x11 survives, rest overrun
    DataReady = 1'b0;
    preamble(16, 1'b1);
    exp_bytes.push_back(8'h11);
    send_byte(8'h11, 8, 8);
    send_byte(8'h22, 8, 8);
    send_byte(8'h33, 8, 8);
    exp_done.push_back(1'b0);
    hold(20);
    check("bp_valid", {31'd0, DataValid}, 32'd1);
    check("bp_data_held", {24'd0, DataOut}, 32'h11);
    check("bp_overrun", {31'd0, Overrun}, 32'd1);
    check("bp_done_left", exp_done.size(), 32'd0);
    ClearStatus = 1'b1;
    hold(1);
    ClearStatus = 1'b0;
    check("overrun_cleared", {31'd0, Overrun}, 32'd0);
    check("bp_valid_after_clear", {31'd0, DataValid}, 32'd1);
    DataReady = 1'b1;
    hold(1);
    check("bp_valid_after_xfer", {31'd0, DataValid}, 32'd0);
    check("bp_bytes_left", exp_bytes.size(), 32'd0);
    idle_line(10);

    // Short preamble: no framing at all
    saw_active = 1'b0; saw_valid = 1'b0;
    preamble(8, 1'b1);
    hold(20);
    check("short_no_active", {31'd0, saw_active}, 32'd0);
    check("short_no_valid", {31'd0, saw_valid}, 32'd0);
    idle_line(10);

    // Line fault after four bits of 0x5A
    saw_valid = 1'b0;
    preamble(16, 1'b1);
    send_bit(1'b0, 8); send_bit(1'b1, 8); send_bit(1'b0, 8); send_bit(1'b1, 8);
    exp_done.push_back(1'b1);
    sample(1'b1, 1'b1); sample(1'b1, 1'b1); sample(1'b1, 1'b1);
    idle_line(5);
    check("fault_done_left", exp_done.size(), 32'd0);
    check("fault_active_low", {31'd0, FrameActive}, 32'd0);
    check("fault_no_valid", {31'd0, saw_valid}, 32'd0);
    idle_line(10);

    // Jitter 7/9 on byte 0xC3, then three residual bits
    preamble(16, 1'b1);
    exp_bytes.push_back(8'hC3);
    send_byte(8'hC3, 7, 9);
    send_bit(1'b1, 8); send_bit(1'b0, 8); send_bit(1'b1, 8);
    exp_done.push_back(1'b1);
    hold(20);
    check("jitter_bytes_left", exp_bytes.size(), 32'd0);
    check("jitter_done_left", exp_done.size(), 32'd0);
    idle_line(10);

    // Reset in the middle of a frame drops everything
    preamble(16, 1'b1);
    send_bit(1'b1, 8);
    ResetN = 1'b0;
    #1;
    check("midframe_reset_outputs", {19'd0, outs()}, 32'd0);
    idle_line(3);
    ResetN = 1'b1;
    send_bit(1'b1, 8); send_bit(1'b1, 8);
    hold(20);
    check("after_reset_inactive", {31'd0, FrameActive}, 32'd0);
    check("final_bytes_left", exp_bytes.size(), 32'd0);
    check("final_done_left", exp_done.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
